// File: rtl/accel_pkg.sv
// Shared types and default geometry for the convolution accelerator datapath.
package accel_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SIZE  = 9;

    typedef logic [DEFAULT_WIDTH-1:0]                   elem_t;
    typedef logic [DEFAULT_SIZE-1:0][DEFAULT_WIDTH-1:0] vec_t;

endpackage

// File: rtl/hpu_lane_mul.sv
// One combinational multiplier lane: p is the low WIDTH bits of a*b.
module hpu_lane_mul #(
    parameter int WIDTH = accel_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    // A WIDTH-sized multiply is the low half of the full 2*WIDTH product,
    // which is identical for signed and unsigned operands.
    assign p = a * b;

endmodule

// File: rtl/hadamard_product_unit.sv
// Element-wise kernel x patch multiplier with a one-cycle registered result.
module hadamard_product_unit
    import accel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SIZE  = DEFAULT_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SIZE-1:0][WIDTH-1:0]  kernel,
    input  logic [SIZE-1:0][WIDTH-1:0]  patch,
    input  logic                        buffer_valid,
    output logic                        mul_valid,
    output logic [SIZE-1:0][WIDTH-1:0]  dout
);

    logic [SIZE-1:0][WIDTH-1:0] prod;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        hpu_lane_mul #(.WIDTH(WIDTH)) u_lane (
            .a (kernel[i]),
            .b (patch[i]),
            .p (prod[i])
        );
    end

    // Valid-only handshake: buffer_valid is sampled at each rising edge and a
    // result appears one cycle later with mul_valid=1; there is no ready, so the
    // consumer must take every result. dout only loads on valid input, so it
    // holds its last result (and ignores unknown inputs) while buffer_valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout      <= '0;
            mul_valid <= 1'b0;
        end else begin
            mul_valid <= buffer_valid;
            if (buffer_valid) begin
                dout <= prod;
            end
        end
    end

endmodule

// File: tb/tb_hadamard_product_unit.sv
// Directed self-checking bench for hadamard_product_unit.
module tb_hadamard_product_unit;
    import accel_pkg::*;

    logic clk = 1'b0;
    logic rst;
    vec_t kernel;
    vec_t patch;
    logic buffer_valid;
    logic mul_valid;
    vec_t dout;

    int checks = 0;
    int errors = 0;
    vec_t exp_v;
    vec_t last_v;

    hadamard_product_unit #(.WIDTH(32), .SIZE(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .kernel       (kernel),
        .patch        (patch),
        .buffer_valid (buffer_valid),
        .mul_valid    (mul_valid),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with live, valid inputs: outputs must clear immediately and stay clear.
        rst          = 1'b1;
        buffer_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            kernel[i] = 32'd3;
            patch[i]  = 32'(i + 1);
        end
        #1;
        check_vec("reset_dout_async", dout, '0);
        check_bit("reset_valid_async", mul_valid, 1'b0);
        step();
        step();
        check_vec("reset_dout_held", dout, '0);
        check_bit("reset_valid_held", mul_valid, 1'b0);

        // First edge after release registers 3*(i+1).
        rst = 1'b0;
        step();
        for (int i = 0; i < 9; i++) exp_v[i] = 32'(3 * (i + 1));
        check_vec("post_reset_dout", dout, exp_v);
        check_bit("post_reset_valid", mul_valid, 1'b1);

        // Basic product sequence.
        kernel    = '0;
        patch     = '0;
        kernel[0] = 32'd10;
        kernel[1] = 32'd5;
        step();
        check_vec("basic_zero_patch", dout, '0);
        check_bit("basic_valid", mul_valid, 1'b1);
        patch[0] = 32'd10;
        step();
        exp_v    = '0;
        exp_v[0] = 32'd100;
        check_vec("basic_lane0", dout, exp_v);
        patch[1] = 32'd6;
        step();
        exp_v[1] = 32'd30;
        check_vec("basic_lane01", dout, exp_v);

        // All lanes: kernel=i+1, patch=2(i+1) -> 2,8,18,...,162.
        for (int i = 0; i < 9; i++) begin
            kernel[i] = 32'(i + 1);
            patch[i]  = 32'(2 * (i + 1));
        end
        step();
        exp_v = {32'd162, 32'd128, 32'd98, 32'd72, 32'd50, 32'd32, 32'd18, 32'd8, 32'd2};
        check_vec("all_lanes", dout, exp_v);

        // Truncation to the low 32 bits.
        kernel    = '0;
        patch     = '0;
        kernel[8] = 32'h0001_0000;
        patch[8]  = 32'h0001_0000;
        kernel[3] = 32'hFFFF_FFFF;
        patch[3]  = 32'd2;
        kernel[0] = 32'h8000_0001;
        patch[0]  = 32'd3;
        kernel[5] = 32'h0001_0000;
        patch[5]  = 32'h0000_0003;
        step();
        exp_v    = '0;
        exp_v[3] = 32'hFFFF_FFFE;
        exp_v[0] = 32'h8000_0003;
        exp_v[5] = 32'h0003_0000;
        check_vec("truncation", dout, exp_v);
        last_v = exp_v;

        // Valid gating: random inputs with buffer_valid low must not move dout.
        buffer_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 9; i++) begin
                kernel[i] = $urandom();
                patch[i]  = $urandom();
            end
            step();
            check_vec("gated_hold", dout, last_v);
            check_bit("gated_valid", mul_valid, 1'b0);
        end
        kernel = 'x;
        patch  = 'x;
        step();
        check_vec("gated_x_inputs", dout, last_v);

        // One-cycle pulse with new products 7*(i+100).
        for (int i = 0; i < 9; i++) begin
            kernel[i] = 32'd7;
            patch[i]  = 32'(i + 100);
        end
        buffer_valid = 1'b1;
        step();
        for (int i = 0; i < 9; i++) exp_v[i] = 32'(7 * (i + 100));
        check_vec("pulse_dout", dout, exp_v);
        check_bit("pulse_valid", mul_valid, 1'b1);
        buffer_valid = 1'b0;
        step();
        check_bit("pulse_end_valid", mul_valid, 1'b0);
        check_vec("pulse_end_hold", dout, exp_v);

        // Streaming: vector s has kernel=s+1, patch=i+2; result one cycle later.
        buffer_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 9; i++) begin
                kernel[i] = 32'(s + 1);
                patch[i]  = 32'(i + 2);
            end
            step();
            for (int i = 0; i < 9; i++) exp_v[i] = 32'((s + 1) * (i + 2));
            check_vec("stream_dout", dout, exp_v);
            check_bit("stream_valid", mul_valid, 1'b1);
        end

        // Reset mid-stream, asynchronously between edges.
        #2;
        rst = 1'b1;
        #1;
        check_vec("mid_reset_dout", dout, '0);
        check_bit("mid_reset_valid", mul_valid, 1'b0);
        @(negedge clk);
        buffer_valid = 1'b0;
        rst          = 1'b0;
        step();
        check_vec("release_idle_dout", dout, '0);
        check_bit("release_idle_valid", mul_valid, 1'b0);
        for (int i = 0; i < 9; i++) begin
            kernel[i] = 32'(i);
            patch[i]  = 32'(i);
        end
        buffer_valid = 1'b1;
        step();
        exp_v = {32'd64, 32'd49, 32'd36, 32'd25, 32'd16, 32'd9, 32'd4, 32'd1, 32'd0};
        check_vec("release_first_dout", dout, exp_v);
        check_bit("release_first_valid", mul_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hadamard_product_unit.md
Name:
hadamard_product_unit

Overview:
- Element-wise (Hadamard) multiplier for the convolution accelerator.
- Takes a SIZE-element kernel vector and a SIZE-element input-patch vector, each flattened from a 3x3 window by default.
- Produces the SIZE per-element products, registered, with a valid flag.
- Sits between the kernel/patch buffers (upstream, which assert buffer_valid) and the adder tree (downstream, which consumes mul_valid/dout).

Parameters:
- WIDTH, 32, bit width of each kernel, patch and product element.
- SIZE, 9, number of elements (lanes) per vector.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- kernel  input  [SIZE-1:0][WIDTH-1:0]  packed kernel vector; element i occupies bits i*WIDTH +: WIDTH.
- patch  input  [SIZE-1:0][WIDTH-1:0]  packed patch vector; same layout as kernel.
- buffer_valid  input  1  kernel and patch are valid this cycle.
- mul_valid  output  1  dout holds products of a valid input set.
- dout  output  [SIZE-1:0][WIDTH-1:0]  packed product vector; dout[i] = kernel[i]*patch[i].

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset (rst=1, any time, independent of clk):
  - dout = 0 for all lanes.
  - mul_valid = 0.
  - Both hold while rst is high.
- Latency is exactly 1 cycle. At a rising edge with rst=0 and buffer_valid=1:
  - dout[i] <= low WIDTH bits of kernel[i]*patch[i], for every i in 0..SIZE-1.
  - mul_valid <= 1.
- At a rising edge with rst=0 and buffer_valid=0:
  - dout holds its previous value.
  - mul_valid <= 0.
- Arithmetic:
  - Full 2*WIDTH product formed internally, then truncated to the low WIDTH bits. No saturation, no overflow flag.
  - The low WIDTH bits are identical for signed and unsigned operands, so dout is correct for both two's-complement and unsigned data.
- Lanes are fully independent; no cross-lane carries.
- No backpressure and no handshake beyond the valid flag:
  - Downstream must accept a result every cycle mul_valid=1.
  - Back-to-back valid inputs give back-to-back results, one per cycle.
- Input changes while buffer_valid=1 are sampled only at the clock edge. Combinational glitches never reach dout.
- Reset deasserted mid-stream: the first result is the one from the first edge with buffer_valid=1 after release.
- No X propagation from the outputs after reset. Inputs that are X while buffer_valid=0 must not disturb dout.

Decomposition:
- Shared package (accel_pkg):
  - Default WIDTH and SIZE constants.
  - Typedef for one element: logic [WIDTH-1:0].
  - Typedef for a packed vector: logic [SIZE-1:0][WIDTH-1:0].
- One sub-module, hpu_lane_mul, instantiated SIZE times via generate.
  - Inputs: a, b (WIDTH each).
  - Output: p (WIDTH), the truncated product.
  - Purely combinational, so the multiplier implementation can later be pipelined or replaced with DSP inference.
- The top level holds the dout and mul_valid registers.

Test Plan:
- Reset: assert rst with nonzero inputs and buffer_valid=1 -> dout=0 and mul_valid=0 immediately and throughout; after release, first edge registers the products.
- Basic product: kernel[0]=10, kernel[1]=5, patch=0, buffer_valid=1 -> next cycle dout all 0, mul_valid=1. Then patch[0]=10 -> dout[0]=100. Then patch[1]=6 -> dout[0]=100, dout[1]=30, others 0.
- All lanes: kernel[i]=i+1, patch[i]=2*(i+1) -> dout[i]=2*(i+1)^2, i.e. 2, 8, 18, ..., 162.
- Truncation: kernel[8]=32'h0001_0000, patch[8]=32'h0001_0000 -> dout[8]=0. Also kernel[3]=32'hFFFF_FFFF, patch[3]=2 -> dout[3]=32'hFFFF_FFFE.
- Valid gating: buffer_valid=0 while inputs change randomly -> dout holds the last valid result, mul_valid=0. Reassert for one cycle -> a one-cycle mul_valid pulse with the new products.
- Streaming: 5 consecutive valid vectors -> 5 consecutive results, each exactly one cycle after its input, with mul_valid continuously 1.
